// File: rtl/coin_sum_multi.sv
// coin_sum_multi: multi-channel coin accumulator for the ticket vending datapath.
// Coin strobes from NCH acceptor channels are arbitrated round-robin. Each
// granted coin is added to a saturating running credit. The credit is compared
// against the ticket price, and change is reported once per transaction.
module coin_sum_multi #(
    parameter int DW      = 8,     // width of one coin value
    parameter int SUM_W   = 12,    // width of credit, price and change
    parameter int NCH     = 2,     // number of coin channels (1..8)
    parameter int MAX_SUM = 4095   // credit saturation ceiling
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frt_fg,
    input  logic [NCH-1:0]      in_RDY,
    input  logic [NCH*DW-1:0]   DATA_in,
    input  logic [SUM_W-1:0]    price,
    output logic                out_RDY,
    output logic                state_cmp,
    output logic [SUM_W-1:0]    DATA_out,
    output logic [SUM_W-1:0]    change,
    output logic                ovf,
    output logic                busy
);

    localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_ADD,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NCH-1:0]     r_pend;
    logic [NCH-1:0]     w_pend_nxt;
    logic [NCH-1:0]     w_req;
    logic               r_clr_pend;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   w_rr_nxt;
    logic [PTR_W-1:0]   r_gnt;
    logic [PTR_W-1:0]   w_gnt;
    logic               w_found;
    logic               w_grant;
    logic               r_live;
    logic [DW-1:0]      r_coin;

    logic [SUM_W-1:0]   r_data_out;
    logic [SUM_W-1:0]   r_change;
    logic               r_state_cmp;
    logic               r_ovf;
    logic               r_out_rdy;

    logic [SUM_W-1:0]   w_base;
    logic [SUM_W:0]     w_sum;
    logic               w_sat;
    logic [SUM_W-1:0]   w_credit;
    logic               w_ovf_nxt;
    logic               w_cmp;

    // Channel index 'off' positions after 'base', wrapping at NCH.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                   input int off);
        int s;
        s = int'(base) + off;
        if (s >= NCH) s = s - NCH;
        return PTR_W'(s);
    endfunction

    // Round-robin arbiter: first requester at or after the pointer wins.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_req   = r_pend | in_RDY;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && w_req[wrap_add(r_rr_ptr, i)]) begin
                w_found = 1'b1;
                w_gnt   = wrap_add(r_rr_ptr, i);
            end
        end
        w_grant  = (r_state == S_IDLE) && w_found;
        w_rr_nxt = wrap_add(w_gnt, 1);
    end

    // Pending strobes accumulate; the granted bit is dropped unless a fresh
    // strobe on that channel coincides with a pended one.
    always_comb begin
        w_pend_nxt = r_pend | in_RDY;
        if (w_grant) begin
            w_pend_nxt[w_gnt] = r_pend[w_gnt] & in_RDY[w_gnt];
        end
    end

    // Saturating accumulate of the captured coin onto the running credit.
    always_comb begin
        w_base    = r_clr_pend ? '0 : r_data_out;
        w_sum     = {1'b0, w_base} + {{(SUM_W + 1 - DW){1'b0}}, r_coin};
        w_sat     = (w_sum > (SUM_W + 1)'(MAX_SUM));
        w_credit  = w_sat ? SUM_W'(MAX_SUM) : w_sum[SUM_W-1:0];
        w_ovf_nxt = (r_ovf & ~r_clr_pend) | w_sat;
        w_cmp     = (w_credit >= price);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state: one coin per four cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_ADD;
            S_ADD:     w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Arbitration, capture and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_clr_pend  <= 1'b0;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_live      <= 1'b0;
            r_coin      <= '0;
            r_data_out  <= '0;
            r_change    <= '0;
            r_state_cmp <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_rdy   <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            // A first-coin flag survives until an ADD consumes it; one raised
            // during ADD itself belongs to the next transaction.
            r_clr_pend <= frt_fg | (r_clr_pend & (r_state != S_ADD));
            r_out_rdy  <= (r_state == S_ADD);

            if (w_grant) begin
                r_gnt    <= w_gnt;
                r_live   <= in_RDY[w_gnt];
                r_rr_ptr <= w_rr_nxt;
            end

            // Data is valid only the cycle after its own strobe; a grant from
            // the pending register has no valid data and adds nothing.
            if (r_state == S_CAPTURE) begin
                r_coin <= r_live ? DATA_in[r_gnt*DW +: DW] : '0;
            end

            if (r_state == S_ADD) begin
                r_data_out  <= w_credit;
                r_ovf       <= w_ovf_nxt;
                r_state_cmp <= w_cmp;
                r_change    <= w_cmp ? (w_credit - price) : '0;
            end
        end
    end

    assign out_RDY   = r_out_rdy;
    assign state_cmp = r_state_cmp;
    assign DATA_out  = r_data_out;
    assign change    = r_change;
    assign ovf       = r_ovf;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_coin_sum_multi.sv
// tb_coin_sum_multi: directed vector table, hand-written multi-cycle
// sequences and randomized traffic against a transaction-level model.
module tb_coin_sum_multi;

    localparam int NCH   = 2;
    localparam int DW    = 8;
    localparam int SUM_W = 12;
    localparam int MAXS  = 20;

    logic                clk = 1'b0;
    logic                rst;
    logic                frt_fg;
    logic [NCH-1:0]      in_RDY;
    logic [NCH*DW-1:0]   DATA_in;
    logic [SUM_W-1:0]    price;
    logic                out_RDY;
    logic                state_cmp;
    logic [SUM_W-1:0]    DATA_out;
    logic [SUM_W-1:0]    change;
    logic                ovf;
    logic                busy;

    int n_cmp  = 0;
    int n_fail = 0;

    coin_sum_multi #(
        .DW(DW), .SUM_W(SUM_W), .NCH(NCH), .MAX_SUM(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .frt_fg(frt_fg), .in_RDY(in_RDY),
        .DATA_in(DATA_in), .price(price), .out_RDY(out_RDY),
        .state_cmp(state_cmp), .DATA_out(DATA_out), .change(change),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: a coin is granted, its value is read one cycle later,
    // the credit is updated one cycle after that, and the result is announced
    // for one cycle. m_age counts cycles since the grant (-1 = no transaction).
    int             m_credit = 0;
    int             m_change = 0;
    int             m_ptr    = 0;
    int             m_ch     = 0;
    int             m_coin   = 0;
    int             m_age    = -1;
    bit             m_ovf    = 1'b0;
    bit             m_cmp    = 1'b0;
    bit             m_rdy    = 1'b0;
    bit             m_clr    = 1'b0;
    bit             m_live   = 1'b0;
    bit [NCH-1:0]   m_pend   = '0;

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_edge();
        bit [NCH-1:0] p0;
        bit [NCH-1:0] req;
        int           age0;
        bit           clr0;
        bit           found;
        int           c;
        int           s;
        if (rst) begin
            m_credit = 0; m_change = 0; m_ptr = 0; m_ch = 0; m_coin = 0;
            m_age = -1; m_ovf = 0; m_cmp = 0; m_rdy = 0; m_clr = 0;
            m_live = 0; m_pend = '0;
            return;
        end
        age0   = m_age;
        clr0   = m_clr;
        p0     = m_pend;
        req    = p0 | in_RDY;
        m_pend = req;
        m_rdy  = (age0 == 1);
        if (age0 == -1) begin
            if (req != '0) begin
                found = 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    c = (m_ptr + k) % NCH;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        m_ch  = c;
                    end
                end
                m_live       = in_RDY[m_ch];
                m_pend[m_ch] = p0[m_ch] & in_RDY[m_ch];
                m_ptr        = (m_ch + 1) % NCH;
                m_age        = 0;
            end
        end else if (age0 == 0) begin
            m_coin = m_live ? int'(DATA_in[m_ch*DW +: DW]) : 0;
            m_age  = 1;
        end else if (age0 == 1) begin
            s        = (clr0 ? 0 : m_credit) + m_coin;
            m_ovf    = (clr0 ? 1'b0 : m_ovf) | (s > MAXS);
            m_credit = (s > MAXS) ? MAXS : s;
            m_cmp    = (m_credit >= int'(price));
            m_change = m_cmp ? (m_credit - int'(price)) : 0;
            m_age    = 2;
        end else begin
            m_age = -1;
        end
        m_clr = frt_fg | (clr0 && age0 != 1);
    endtask

    // One clock: update the model with current inputs, then sample after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},  int'(out_RDY),   0);
        check({tag, "_cmp"},  int'(state_cmp), 0);
        check({tag, "_sum"},  int'(DATA_out),  0);
        check({tag, "_chg"},  int'(change),    0);
        check({tag, "_ovf"},  int'(ovf),       0);
        check({tag, "_busy"}, int'(busy),      0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit frt;
        int ch;
        int coin;
        int price;
        int exp_sum;
        bit exp_cmp;
        int exp_chg;
        bit exp_ovf;
    } vec_t;

    vec_t vecs[11];

    // Single-channel transaction: strobe at T, data at T+1, result at T+3.
    task automatic do_vec(input string tag, input vec_t v);
        DATA_in        = NCH*DW'($urandom);
        frt_fg         = v.frt;
        in_RDY         = '0;
        in_RDY[v.ch]   = 1'b1;
        price          = SUM_W'(v.price);
        tick();                                   // T+1: capture
        frt_fg         = 1'b0;
        in_RDY         = '0;
        DATA_in        = NCH*DW'($urandom);
        DATA_in[v.ch*DW +: DW] = DW'(v.coin);
        tick();                                   // T+2: add
        check({tag, "_rdy_early"}, int'(out_RDY), 0);
        check({tag, "_busy"},      int'(busy),    1);
        DATA_in = NCH*DW'($urandom);
        tick();                                   // T+3: result
        check({tag, "_rdy"}, int'(out_RDY),   1);
        check({tag, "_sum"}, int'(DATA_out),  v.exp_sum);
        check({tag, "_cmp"}, int'(state_cmp), int'(v.exp_cmp));
        check({tag, "_chg"}, int'(change),    v.exp_chg);
        check({tag, "_ovf"}, int'(ovf),       int'(v.exp_ovf));
        tick();                                   // T+4: idle again
        check({tag, "_rdy_once"}, int'(out_RDY), 0);
        check({tag, "_idle"},     int'(busy),    0);
    endtask

    initial begin
        rst     = 1'b1;
        frt_fg  = 1'b0;
        in_RDY  = '0;
        DATA_in = '0;
        price   = '0;

        //            frt   ch coin pr  sum  cmp  chg  ovf
        vecs[0]  = '{1'b1, 0,  1,  6,  1, 1'b0,  0, 1'b0}; // first coin
        vecs[1]  = '{1'b0, 0,  5,  6,  6, 1'b1,  0, 1'b0}; // reaches price exactly
        vecs[2]  = '{1'b1, 0, 10,  6, 10, 1'b1,  4, 1'b0}; // new transaction
        vecs[3]  = '{1'b1, 1, 15,  6, 15, 1'b1,  9, 1'b0}; // channel 1
        vecs[4]  = '{1'b0, 1, 10,  6, 20, 1'b1, 14, 1'b1}; // 25 saturates at 20
        vecs[5]  = '{1'b0, 0,  0,  6, 20, 1'b1, 14, 1'b1}; // overflow is sticky
        vecs[6]  = '{1'b1, 0,  3,  6,  3, 1'b0,  0, 1'b0}; // first coin clears ovf
        vecs[7]  = '{1'b0, 1,  1,  6,  4, 1'b0,  0, 1'b0};
        vecs[8]  = '{1'b0, 0,  0,  3,  4, 1'b1,  1, 1'b0}; // zero coin, lower price
        vecs[9]  = '{1'b0, 1, 16,  3, 20, 1'b1, 17, 1'b0}; // exactly at ceiling
        vecs[10] = '{1'b0, 0,  1, 20, 20, 1'b1,  0, 1'b1}; // one past ceiling

        // Reset state.
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        foreach (vecs[i]) do_vec($sformatf("vec%0d", i), vecs[i]);

        // A price change with no coin does not move the registered compare.
        price = SUM_W'(5);
        tick();
        tick();
        check("price_hold_cmp", int'(state_cmp), 1);
        check("price_hold_chg", int'(change),    0);

        // Simultaneous strobes from a fresh reset (pointer at channel 0).
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        frt_fg = 1'b1;
        in_RDY = 2'b11;
        price  = SUM_W'(6);
        tick();                                   // T+1
        frt_fg  = 1'b0;
        in_RDY  = '0;
        DATA_in = {8'd3, 8'd2};
        tick();                                   // T+2
        DATA_in = NCH*DW'($urandom);
        tick();                                   // T+3
        check("pair_ch0_rdy", int'(out_RDY),  1);
        check("pair_ch0_sum", int'(DATA_out), 2);
        check("pair_ch0_cmp", int'(state_cmp), 0);
        tick();                                   // T+4: channel 1 granted from pend
        DATA_in = 16'hFFFF;                       // stale data must not be added
        tick();                                   // T+5
        check("pair_ch1_busy", int'(busy), 1);
        tick();                                   // T+6
        check("pair_ch1_rdy_early", int'(out_RDY), 0);
        tick();                                   // T+7
        check("pair_ch1_rdy", int'(out_RDY),  1);
        check("pair_ch1_sum", int'(DATA_out), 2);
        tick();                                   // T+8: idle, pointer back to 0
        in_RDY = 2'b11;
        price  = SUM_W'(3);
        tick();                                   // T+9
        in_RDY  = '0;
        DATA_in = {8'd7, 8'd1};
        tick();
        tick();                                   // T+11
        check("pair2_first_rdy", int'(out_RDY),  1);
        check("pair2_first_sum", int'(DATA_out), 3);
        check("pair2_first_chg", int'(change),   0);
        repeat (4) tick();                        // T+15
        check("pair2_second_rdy", int'(out_RDY),  1);
        check("pair2_second_sum", int'(DATA_out), 3);
        tick();

        // Reset in the middle of a transaction abandons the coin.
        in_RDY  = 2'b01;
        DATA_in = NCH*DW'($urandom);
        tick();                                   // T+1
        in_RDY  = '0;
        DATA_in = {8'd0, 8'd9};
        tick();                                   // T+2
        rst = 1'b1;
        tick();                                   // T+3
        check_all_zero("midrst");
        rst = 1'b0;
        tick();
        check("midrst_no_rdy", int'(out_RDY), 0);
        do_vec("after_rst", '{1'b0, 0, 4, 6, 4, 1'b0, 0, 1'b0});

        // Randomized traffic against the model, every output every cycle.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst    = ($urandom_range(0, 199) == 0);
            frt_fg = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < NCH; k++) in_RDY[k] = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < NCH; k++) DATA_in[k*DW +: DW] = DW'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) DATA_in[DW-1:0] = 8'hFF;
            if ($urandom_range(0, 15) == 0) price = SUM_W'($urandom_range(0, 24));
            tick();
            check("rnd_rdy",  int'(out_RDY),   int'(m_rdy));
            check("rnd_sum",  int'(DATA_out),  m_credit);
            check("rnd_cmp",  int'(state_cmp), int'(m_cmp));
            check("rnd_chg",  int'(change),    m_change);
            check("rnd_ovf",  int'(ovf),       int'(m_ovf));
            check("rnd_busy", int'(busy),      int'(m_age != -1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
